// File: rtl/flow_rr_mux.sv
// rtl/flow_rr_mux.sv - per-flow FIFOs merged onto one tagged output by a burst round-robin arbiter
module flow_rr_mux #(
    parameter int FLUX   = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int BURST  = 1,
    localparam int TAG_W = (FLUX > 2) ? $clog2(FLUX) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLUX*DATA_W-1:0]  in_din,
    input  logic [FLUX-1:0]         in_write,
    output logic [FLUX-1:0]         in_full,
    input  logic [FLUX-1:0]         flow_en,
    output logic [TAG_W+DATA_W-1:0] out_din,
    output logic                    out_write,
    input  logic                    out_full,
    output logic [FLUX-1:0]         err_ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                    state_q;
    logic [TAG_W-1:0]          g_q;
    logic [TAG_W-1:0]          ptr_q;
    logic [BC_W-1:0]           bc_q;
    logic [CNT_W-1:0]          count_q [FLUX];
    logic [PTR_W-1:0]          wr_ptr_q [FLUX];
    logic [PTR_W-1:0]          rd_ptr_q [FLUX];
    logic [DATA_W-1:0]         mem_q [FLUX][DEPTH];
    logic [TAG_W+DATA_W-1:0]   out_din_q;
    logic                      out_write_q;
    logic [FLUX-1:0]           err_q;

    logic [FLUX-1:0]  full;
    logic [FLUX-1:0]  elig;
    logic [FLUX-1:0]  push;
    logic [FLUX-1:0]  pop;
    logic             cont;
    logic             burst_end;
    logic [TAG_W-1:0] g_next;
    logic [TAG_W-1:0] scan_start;
    logic [TAG_W-1:0] scan_sel;
    logic             found;
    logic [TAG_W-1:0] sel;
    logic             have;
    logic             do_pop;

    assign in_full   = full;
    assign out_din   = out_din_q;
    assign out_write = out_write_q;
    assign err_ovf   = err_q;

    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            full[i] = (count_q[i] == CNT_W'(DEPTH));
            elig[i] = (count_q[i] != '0) && flow_en[i];
            push[i] = in_write[i] && !full[i];
        end
    end

    // Burst end is resolved lazily at the next decision edge, so the re-grant costs no bubble.
    always_comb begin
        cont       = (state_q == GRANT) && elig[g_q] && (bc_q < BC_W'(BURST));
        burst_end  = (state_q == GRANT) && !cont;
        g_next     = (g_q == TAG_W'(FLUX - 1)) ? '0 : g_q + TAG_W'(1);
        scan_start = burst_end ? g_next : ptr_q;
        found      = 1'b0;
        scan_sel   = '0;
        for (int k = 0; k < FLUX; k++) begin
            if (!found && elig[(int'(scan_start) + k) % FLUX]) begin
                found    = 1'b1;
                scan_sel = TAG_W'((int'(scan_start) + k) % FLUX);
            end
        end
        sel    = cont ? g_q : scan_sel;
        have   = cont || found;
        do_pop = !out_full && have;
        for (int i = 0; i < FLUX; i++) begin
            pop[i] = do_pop && (sel == TAG_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FLUX; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_din[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= '0;
            ptr_q       <= '0;
            bc_q        <= '0;
            out_din_q   <= '0;
            out_write_q <= 1'b0;
            err_q       <= '0;
            for (int i = 0; i < FLUX; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FLUX; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                if (push[i] && !pop[i])      count_q[i] <= count_q[i] + CNT_W'(1);
                else if (!push[i] && pop[i]) count_q[i] <= count_q[i] - CNT_W'(1);
                err_q[i] <= err_q[i] | (in_write[i] & full[i]);
            end
            if (out_full) begin
                out_write_q <= 1'b0;
            end else begin
                if (have) begin
                    out_din_q   <= {sel, mem_q[sel][rd_ptr_q[sel]]};
                    out_write_q <= 1'b1;
                    state_q     <= GRANT;
                    g_q         <= sel;
                    bc_q        <= cont ? bc_q + BC_W'(1) : BC_W'(1);
                end else begin
                    out_write_q <= 1'b0;
                    state_q     <= IDLE;
                    bc_q        <= '0;
                end
                if (burst_end) ptr_q <= g_next;
            end
        end
    end
endmodule

// File: tb/tb_flow_rr_mux.sv
// tb/tb_flow_rr_mux.sv - directed bench for flow_rr_mux with BURST=1 and BURST=4 instances
module tb_flow_rr_mux;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_din = '0;
    logic [3:0]  in_write = '0;
    logic [3:0]  flow_en = 4'hF;
    logic        out_full = 1'b0;
    logic [3:0]  in_full1, in_full4, err1, err4;
    logic [9:0]  od1, od4;
    logic        ow1, ow4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int viol     = 0;
    logic [9:0] q1[$];
    logic [9:0] q4[$];
    int         c4[$];

    always #5 clk = ~clk;

    flow_rr_mux #(.FLUX(4), .DATA_W(8), .DEPTH(16), .BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .in_din(in_din), .in_write(in_write), .in_full(in_full1),
        .flow_en(flow_en), .out_din(od1), .out_write(ow1), .out_full(out_full), .err_ovf(err1)
    );

    flow_rr_mux #(.FLUX(4), .DATA_W(8), .DEPTH(16), .BURST(4)) u_b4 (
        .clk(clk), .rst(rst), .in_din(in_din), .in_write(in_write), .in_full(in_full4),
        .flow_en(flow_en), .out_din(od4), .out_write(ow4), .out_full(out_full), .err_ovf(err4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic fa;
        fa = out_full;
        @(posedge clk);
        #1;
        cyc++;
        if (ow1 && fa) viol++;
        if (ow1) q1.push_back(od1);
        if (ow4) begin
            q4.push_back(od4);
            c4.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_write = '0;
        out_full = 1'b0;
        flow_en = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        q1.delete();
        q4.delete();
        c4.delete();
    endtask

    task automatic set_word(input int f, input int v);
        in_din[f*8 +: 8] = 8'(v);
    endtask

    initial begin
        int nexp[4];
        int errs;
        int t3;
        logic [9:0] v;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_write", {31'd0, ow1}, 32'd0);
        check("rst_out_din", {22'd0, od1}, 32'd0);
        check("rst_in_full", {28'd0, in_full1}, 32'd0);
        check("rst_err", {28'd0, err1}, 32'd0);
        do_reset();

        // BURST=1 round robin over four flows
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) set_word(i, i*16 + k);
            in_write = 4'hF;
            tick();
        end
        in_write = '0;
        repeat (40) tick();
        check("rr_count", q1.size(), 32);
        for (int j = 0; j < 32 && j < q1.size(); j++) begin
            check($sformatf("rr_word%0d", j), {22'd0, q1[j]},
                  {22'd0, 2'(j % 4), 8'((j % 4)*16 + j/4)});
        end

        // BURST=4 with flows 0 and 2
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_word(0, k);
            set_word(2, 32 + k);
            in_write = 4'b0101;
            tick();
        end
        in_write = '0;
        repeat (20) tick();
        check("burst_count", q4.size(), 16);
        if (q4.size() == 16) begin
            check("burst_no_bubble", c4[15] - c4[0], 15);
            for (int j = 0; j < 16; j++) begin
                check($sformatf("burst_word%0d", j), {22'd0, q4[j]},
                      {22'd0, ((j/4) % 2 == 0) ? 2'd0 : 2'd2,
                       8'(((j/4) % 2 == 0 ? 0 : 32) + (j/8)*4 + j%4)});
            end
        end

        // overflow with back-pressure
        do_reset();
        out_full = 1'b1;
        for (int k = 0; k < 17; k++) begin
            set_word(1, k);
            in_write = 4'b0010;
            tick();
            if (k == 15) begin
                check("ovf_full_16", {28'd0, in_full1}, 32'h2);
                check("ovf_err_16", {28'd0, err1}, 32'h0);
            end
        end
        in_write = '0;
        check("ovf_err_17", {28'd0, err1}, 32'h2);
        check("ovf_full_17", {28'd0, in_full1}, 32'h2);
        check("ovf_no_out", q1.size(), 0);
        out_full = 1'b0;
        repeat (25) tick();
        check("ovf_drain_count", q1.size(), 16);
        for (int j = 0; j < 16 && j < q1.size(); j++) begin
            check($sformatf("ovf_word%0d", j), {22'd0, q1[j]}, {22'd0, 2'd1, 8'(j)});
        end
        check("ovf_err_sticky", {28'd0, err1}, 32'h2);
        check("ovf_full_clear", {28'd0, in_full1}, 32'h0);

        // out_full toggling every cycle under load
        do_reset();
        viol = 0;
        for (int t = 0; t < 60; t++) begin
            out_full = t[0];
            if (t < 6) begin
                for (int i = 0; i < 4; i++) set_word(i, i*16 + t);
                in_write = 4'hF;
            end else begin
                in_write = '0;
            end
            tick();
        end
        out_full = 1'b0;
        repeat (10) tick();
        check("bp_violations", viol, 0);
        errs = 0;
        for (int i = 0; i < 4; i++) nexp[i] = 0;
        foreach (q1[j]) begin
            v = q1[j];
            if (int'(v[7:0]) != int'(v[9:8])*16 + nexp[v[9:8]]) errs++;
            nexp[v[9:8]]++;
        end
        check("bp_order", errs, 0);
        for (int i = 0; i < 4; i++) check($sformatf("bp_count_f%0d", i), nexp[i], 6);

        // flow enable gating
        do_reset();
        flow_en = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            set_word(3, 48 + k);
            set_word(0, k);
            in_write = (k < 2) ? 4'b1001 : 4'b1000;
            tick();
        end
        in_write = '0;
        repeat (10) tick();
        t3 = 0;
        foreach (q1[j]) if (q1[j][9:8] == 2'd3) t3++;
        check("en_no_tag3", t3, 0);
        check("en_count", q1.size(), 2);
        q1.delete();
        flow_en = 4'hF;
        repeat (10) tick();
        check("en_release_count", q1.size(), 4);
        for (int j = 0; j < 4 && j < q1.size(); j++) begin
            check($sformatf("en_word%0d", j), {22'd0, q1[j]}, {22'd0, 2'd3, 8'(48 + j)});
        end

        // reset mid-burst
        do_reset();
        flow_en = 4'b0111;
        for (int k = 0; k < 16; k++) begin
            set_word(0, k);
            set_word(3, 48 + k);
            in_write = 4'b1001;
            tick();
        end
        in_write = '0;
        check("mid_pre_write", {31'd0, ow4}, 32'd1);
        check("mid_pre_full", {28'd0, in_full4}, 32'h8);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_write", {31'd0, ow4}, 32'd0);
        check("mid_rst_full", {28'd0, in_full4}, 32'h0);
        check("mid_rst_din", {22'd0, od4}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        flow_en = 4'hF;
        set_word(2, 8'hA5);
        in_write = 4'b0100;
        tick();
        in_write = '0;
        check("post_rst_n", {31'd0, ow4}, 32'd0);
        tick();
        check("post_rst_n1_write", {31'd0, ow4}, 32'd1);
        check("post_rst_n1_din", {22'd0, od4}, {22'd0, 2'd2, 8'hA5});
        tick();
        check("post_rst_n2_write", {31'd0, ow4}, 32'd0);
        repeat (5) tick();
        check("post_rst_discard", {31'd0, ow4}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flow_rr_mux.md
FLOW_RR_MUX -- requirements
Module: flow_rr_mux

Interface
REQ-001 SHALL have parameter FLUX, default 4, meaning number of input flows (2..16).
REQ-002 SHALL have parameter DATA_W, default 8, meaning payload width per word.
REQ-003 SHALL have parameter DEPTH, default 16, meaning per-flow FIFO depth in words (power of 2, at least 2).
REQ-004 SHALL have parameter BURST, default 1, meaning maximum consecutive words granted to one flow before rotation (1..DEPTH).
REQ-005 SHALL define derived TAG_W = max(1, clog2(FLUX)).
REQ-006 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port in_din, input, FLUX*DATA_W bits: per-flow payload, flow i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port in_write, input, FLUX bits: per-flow write strobe.
REQ-010 SHALL have port in_full, output, FLUX bits: per-flow FIFO full.
REQ-011 SHALL have port flow_en, input, FLUX bits: per-flow arbitration enable.
REQ-012 SHALL have port out_din, output, TAG_W+DATA_W bits: {flow id, payload}.
REQ-013 SHALL have port out_write, output, 1 bit: out_din valid this cycle.
REQ-014 SHALL have port out_full, input, 1 bit: downstream full, back-pressure.
REQ-015 SHALL have port err_ovf, output, FLUX bits: sticky per-flow overflow flag.

Function
REQ-016 SHALL push in_din slice i into FIFO i at a rising edge where in_write[i]=1 and in_full[i]=0.
REQ-017 SHALL drive in_full[i] from registered occupancy only: 1 when count_i==DEPTH, with no combinational path from out_full.
REQ-018 SHALL drop a write with in_write[i]=1 while in_full[i]=1, even if the same edge pops flow i, and set err_ovf[i]=1 until reset.
REQ-019 SHALL treat flow i as eligible when count_i>0 and flow_en[i]=1.
REQ-020 SHALL run an arbiter with states IDLE (no grant) and GRANT (grant id g, burst counter bc) and a rotation pointer ptr.
REQ-021 SHALL, at an edge with out_full=0 in IDLE, or in GRANT once the burst ends, select the first eligible flow scanning ptr, ptr+1, ... modulo FLUX; if none is eligible, go to IDLE.
REQ-022 SHALL, at each edge with out_full=0 and a granted eligible flow, pop one word and register out_din={g, word} and out_write=1.
REQ-023 SHALL register out_write=0 and leave out_din unchanged at any edge where out_full=1 or no flow is eligible.
REQ-024 SHALL freeze bc, g and all FIFO state while out_full=1.
REQ-025 SHALL increment bc per popped word and end the burst when bc reaches BURST or flow g becomes ineligible, then set ptr=(g+1) mod FLUX.
REQ-026 SHALL make a re-grant at the burst-end edge (REQ-021) in the same cycle, with no bubble cycle.
REQ-027 SHALL give a latency of 1 cycle: a word pushed into an empty FIFO at edge N, with a free grant and out_full=0, appears with out_write=1 after edge N+1.
REQ-028 SHALL emit words of each flow in their write order, with no duplication or loss except drops under REQ-018.
REQ-029 SHALL, on flow_en[i] deassertion, finish the current word, end any burst of i and keep i's FIFO contents for later.
REQ-030 SHALL handle pointer and FIFO index wrap-around modulo FLUX and DEPTH respectively.
REQ-031 SHALL, at an edge with a push and pop on the same non-full flow, leave count_i unchanged.

Reset
REQ-032 SHALL, while rst=1, immediately force all FIFOs empty, in_full=0, out_write=0, out_din=0, err_ovf=0, state IDLE, ptr=0, bc=0.
REQ-033 SHALL apply a reset asserted mid-burst or mid-transfer immediately and discard all buffered words; the first grant after release starts at flow 0.

Verification
REQ-034 SHALL check: FLUX=4, BURST=1, 8 words written per flow simultaneously, out_full=0 -> output tags 0,1,2,3,0,1,... with per-flow payload order preserved; 32 outputs total.
REQ-035 SHALL check: BURST=4, flows 0 and 2 each hold 8 words -> tags 0,0,0,0,2,2,2,2,0,0,0,0,2,2,2,2 with no idle cycle between bursts.
REQ-036 SHALL check: DEPTH=16, out_full=1, 17 writes to flow 1 -> in_full[1]=1 after the 16th, 17th dropped, err_ovf[1]=1; after out_full falls exactly 16 words are emitted.
REQ-037 SHALL check: out_full toggling every cycle under load -> out_write never 1 after an edge sampling out_full=1, and no loss or duplication.
REQ-038 SHALL check: flow_en[3]=0 with data in flow 3 -> no tag-3 outputs; after flow_en[3] rises, the buffered words are emitted in order.
REQ-039 SHALL check: rst pulse mid-burst -> out_write=0 and in_full=0 immediately; after release a single word on flow 2 is emitted with tag 2 one cycle after its write.
